// File: rtl/micro_pkg.sv
// micro_pkg: shared encodings and default widths for the microprogram sequencer.
package micro_pkg;
  localparam int MICRO_ADDR_W = 16;
  localparam int MICRO_OP_W = 6;
  localparam logic [1:0] COND_ALWAYS = 2'b00;
  localparam logic [1:0] COND_Z = 2'b01;
  localparam logic [1:0] COND_NZ = 2'b10;
  localparam logic [1:0] COND_EXT = 2'b11;
  localparam logic [5:0] OP_LOOP_LOAD = 6'h3F;
  typedef enum logic [1:0] {ST_IDLE, ST_RUN, ST_HALT} state_t;
endpackage

// File: rtl/micro_cond_eval.sv
// micro_cond_eval: combinational branch-condition decoder; i_ext is flag_ext or loop-count-nonzero.
module micro_cond_eval
  import micro_pkg::*;
(
  input  logic [1:0] i_condition,
  input  logic       i_flag_zero,
  input  logic       i_ext,
  output logic       o_cond_true
);
  always_comb
    o_cond_true = (i_condition == COND_ALWAYS)
                | ((i_condition == COND_Z) & i_flag_zero)
                | ((i_condition == COND_NZ) & !i_flag_zero)
                | ((i_condition == COND_EXT) & i_ext);
endmodule

// File: rtl/micro_sequencer.sv
// micro_sequencer: micro-PC owner, next-address mux and registered op issue.
// Optional loop counter for condition 11 enabled by MICRO_SEQ_LOOP_CNT_EN.
module micro_sequencer
  import micro_pkg::*;
#(
  parameter int                ADDR_W     = MICRO_ADDR_W,
  parameter int                OP_W       = MICRO_OP_W,
  parameter logic [ADDR_W-1:0] START_ADDR = '0
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              start,
  input  logic              stall,
  input  logic              flag_zero,
  input  logic              flag_ext,
  input  logic [1:0]        condition,
  input  logic              BT,
  input  logic [OP_W-1:0]   OPs,
  input  logic [ADDR_W-1:0] jump_addr,
  output logic [ADDR_W-1:0] upc,
  output logic [OP_W-1:0]   ops_out,
  output logic              ops_valid,
  output logic              busy,
  output logic              done
);
  state_t            r_state, w_state_nx;
  logic [ADDR_W-1:0] r_upc, w_upc_nx, w_upc_inc;
  logic [OP_W-1:0]   r_ops, w_ops_nx;
  logic              r_valid, w_valid_nx, w_cond_true, w_ext, w_loop_ld, w_halt;

  assign w_upc_inc = r_upc + ADDR_W'(1);
  assign w_halt = BT && condition == COND_ALWAYS && jump_addr == r_upc;

  micro_cond_eval u_cond (
    .i_condition(condition),
    .i_flag_zero(flag_zero),
    .i_ext      (w_ext),
    .o_cond_true(w_cond_true)
  );

`ifdef MICRO_SEQ_LOOP_CNT_EN
  logic [15:0] r_loop_cnt;
  logic        w_unused_ext;
  assign w_unused_ext = flag_ext;
  assign w_loop_ld = !BT && OPs == OP_W'(OP_LOOP_LOAD);
  assign w_ext = r_loop_cnt != '0;
  // Counter decrements only on a taken condition-11 branch.
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) r_loop_cnt <= '0;
    else if (r_state == ST_RUN && !stall)
      r_loop_cnt <= w_loop_ld ? 16'(jump_addr)
                  : (BT && condition == COND_EXT && w_cond_true) ? r_loop_cnt - 16'd1
                  : r_loop_cnt;
`else
  assign w_loop_ld = 1'b0;
  assign w_ext = flag_ext;
`endif

  always_comb begin
    w_state_nx = r_state;
    w_upc_nx = r_upc;
    w_ops_nx = r_ops;
    w_valid_nx = 1'b0;
    case (r_state)
      ST_IDLE: if (start) begin
        w_state_nx = ST_RUN;
        w_upc_nx = START_ADDR;
      end
      ST_RUN: if (!stall) begin
        if (!BT) begin
          w_upc_nx = w_upc_inc;
          w_ops_nx = w_loop_ld ? r_ops : OPs;
          w_valid_nx = !w_loop_ld;
        end else if (w_halt) w_state_nx = ST_HALT;
        else w_upc_nx = w_cond_true ? jump_addr : w_upc_inc;
      end
      default: w_state_nx = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      r_state <= ST_IDLE;
      r_upc <= START_ADDR;
      r_ops <= '0;
      r_valid <= 1'b0;
    end else begin
      r_state <= w_state_nx;
      r_upc <= w_upc_nx;
      r_ops <= w_ops_nx;
      r_valid <= w_valid_nx;
    end

  assign upc = r_upc;
  assign ops_out = r_ops;
  assign ops_valid = r_valid;
  assign busy = r_state == ST_RUN;
  assign done = r_state == ST_HALT;
endmodule

// File: tb/tb_micro_sequencer.sv
// tb_micro_sequencer: scoreboard bench; a small ROM model answers the DUT's upc combinationally.
module tb_micro_sequencer;
  logic        clk = 1'b0, rst_n = 1'b0;
  logic        start = 1'b0, stall = 1'b0, flag_zero = 1'b0, flag_ext = 1'b0;
  logic [1:0]  condition;
  logic        BT;
  logic [5:0]  OPs, ops_out;
  logic [15:0] jump_addr, upc;
  logic        ops_valid, busy, done;
  logic [24:0] rom [0:31];
  int          n_pass = 0, n_total = 0;

  typedef struct {
    logic st, sl, fz, fe;
    logic [15:0] upc;
    logic v;
    logic [5:0] ops;
    logic busy, done;
  } ent_t;
  ent_t sb[$];
  ent_t e;

  micro_sequencer dut (
    .clk(clk), .rst_n(rst_n), .start(start), .stall(stall),
    .flag_zero(flag_zero), .flag_ext(flag_ext), .condition(condition), .BT(BT),
    .OPs(OPs), .jump_addr(jump_addr), .upc(upc), .ops_out(ops_out),
    .ops_valid(ops_valid), .busy(busy), .done(done)
  );

  always #5 clk = ~clk;
  always_comb {BT, condition, OPs, jump_addr} = rom[upc[4:0]];

  function automatic logic [24:0] op_w(input logic [5:0] o);
    return {1'b0, 2'b00, o, 16'h0000};
  endfunction
  function automatic logic [24:0] br_w(input logic [1:0] c, input logic [15:0] j);
    return {1'b1, c, 6'h00, j};
  endfunction

  task automatic clear_rom();
    for (int i = 0; i < 32; i++) rom[i] = op_w(6'h00);
  endtask

  task automatic push(input logic st, sl, fz, fe, input logic [15:0] u, input logic v,
                      input logic [5:0] o, input logic b, d);
    ent_t x;
    x.st = st; x.sl = sl; x.fz = fz; x.fe = fe;
    x.upc = u; x.v = v; x.ops = o; x.busy = b; x.done = d;
    sb.push_back(x);
  endtask

  task automatic test_reset();
    #3;
    n_total++;
    if ({upc, ops_valid, ops_out, busy, done} !== {16'h0000, 1'b0, 6'h00, 1'b0, 1'b0})
      $display("FAIL reset: got upc=%h v=%b ops=%h busy=%b done=%b", upc, ops_valid, ops_out, busy, done);
    else n_pass++;
    @(posedge clk); #1 rst_n = 1'b1;
  endtask

  task automatic test_ops_branch();
    int k = 0;
    clear_rom();
    rom[0] = op_w(6'd1); rom[1] = op_w(6'd2); rom[2] = op_w(6'd3);
    rom[3] = br_w(2'b01, 16'h0010);
    rom[4] = op_w(6'd4); rom[5] = op_w(6'd5); rom[6] = op_w(6'd6);
    rom[7] = br_w(2'b00, 16'h0007);
    rom[16] = br_w(2'b00, 16'h0004);
    push(1,0,1,0, 16'h0000, 0, 6'd0, 1, 0);
    push(0,0,1,0, 16'h0001, 1, 6'd1, 1, 0);
    push(0,0,1,0, 16'h0002, 1, 6'd2, 1, 0);
    push(0,0,1,0, 16'h0003, 1, 6'd3, 1, 0);
    push(0,0,1,0, 16'h0010, 0, 6'd3, 1, 0);
    push(0,0,1,0, 16'h0004, 0, 6'd3, 1, 0);
    push(0,0,1,0, 16'h0005, 1, 6'd4, 1, 0);
    push(0,0,1,0, 16'h0006, 1, 6'd5, 1, 0);
    push(0,0,1,0, 16'h0007, 1, 6'd6, 1, 0);
    push(0,0,1,0, 16'h0007, 0, 6'd6, 0, 1);
    push(1,0,1,0, 16'h0007, 0, 6'd6, 0, 0);
    push(0,0,1,0, 16'h0007, 0, 6'd6, 0, 0);
    while (sb.size() > 0) begin
      e = sb.pop_front();
      start = e.st; stall = e.sl; flag_zero = e.fz; flag_ext = e.fe;
      @(posedge clk); #1;
      n_total++; k++;
      if ({upc, ops_valid, ops_out, busy, done} !== {e.upc, e.v, e.ops, e.busy, e.done})
        $display("FAIL ops_branch step %0d: got upc=%h v=%b ops=%h busy=%b done=%b want upc=%h v=%b ops=%h busy=%b done=%b",
                 k, upc, ops_valid, ops_out, busy, done, e.upc, e.v, e.ops, e.busy, e.done);
      else n_pass++;
    end
    start = 1'b0;
  endtask

  task automatic test_stall();
    int k = 0;
    push(1,0,0,0, 16'h0000, 0, 6'd6, 1, 0);
    push(0,0,0,0, 16'h0001, 1, 6'd1, 1, 0);
    push(0,0,0,0, 16'h0002, 1, 6'd2, 1, 0);
    push(0,0,0,0, 16'h0003, 1, 6'd3, 1, 0);
    push(0,0,0,0, 16'h0004, 0, 6'd3, 1, 0);
    push(0,0,0,0, 16'h0005, 1, 6'd4, 1, 0);
    push(0,1,0,0, 16'h0005, 0, 6'd4, 1, 0);
    push(0,1,0,0, 16'h0005, 0, 6'd4, 1, 0);
    push(0,1,0,0, 16'h0005, 0, 6'd4, 1, 0);
    push(0,0,0,0, 16'h0006, 1, 6'd5, 1, 0);
    push(0,0,0,0, 16'h0007, 1, 6'd6, 1, 0);
    push(0,1,0,0, 16'h0007, 0, 6'd6, 1, 0);
    push(1,0,0,0, 16'h0007, 0, 6'd6, 0, 1);
    push(0,0,0,0, 16'h0007, 0, 6'd6, 0, 0);
    while (sb.size() > 0) begin
      e = sb.pop_front();
      start = e.st; stall = e.sl; flag_zero = e.fz; flag_ext = e.fe;
      @(posedge clk); #1;
      n_total++; k++;
      if ({upc, ops_valid, ops_out, busy, done} !== {e.upc, e.v, e.ops, e.busy, e.done})
        $display("FAIL stall step %0d: got upc=%h v=%b ops=%h busy=%b done=%b want upc=%h v=%b ops=%h busy=%b done=%b",
                 k, upc, ops_valid, ops_out, busy, done, e.upc, e.v, e.ops, e.busy, e.done);
      else n_pass++;
    end
    start = 1'b0; stall = 1'b0;
  endtask

  task automatic test_wrap_reset();
    int k = 0;
    clear_rom();
    rom[0] = br_w(2'b10, 16'hFFFF);
    rom[31] = op_w(6'h2A);
    push(1,1,0,0, 16'h0000, 0, 6'd6, 1, 0);
    push(0,0,0,0, 16'hFFFF, 0, 6'd6, 1, 0);
    push(0,0,0,0, 16'h0000, 1, 6'h2A, 1, 0);
    push(0,0,0,0, 16'hFFFF, 0, 6'h2A, 1, 0);
    while (sb.size() > 0) begin
      e = sb.pop_front();
      start = e.st; stall = e.sl; flag_zero = e.fz; flag_ext = e.fe;
      @(posedge clk); #1;
      n_total++; k++;
      if ({upc, ops_valid, ops_out, busy, done} !== {e.upc, e.v, e.ops, e.busy, e.done})
        $display("FAIL wrap step %0d: got upc=%h v=%b ops=%h busy=%b done=%b want upc=%h v=%b ops=%h busy=%b done=%b",
                 k, upc, ops_valid, ops_out, busy, done, e.upc, e.v, e.ops, e.busy, e.done);
      else n_pass++;
    end
    start = 1'b0;
    #2 rst_n = 1'b0;
    #1;
    n_total++;
    if ({upc, ops_valid, ops_out, busy, done} !== {16'h0000, 1'b0, 6'h00, 1'b0, 1'b0})
      $display("FAIL async_reset: got upc=%h v=%b ops=%h busy=%b done=%b", upc, ops_valid, ops_out, busy, done);
    else n_pass++;
    @(posedge clk); #1 rst_n = 1'b1;
    for (int i = 0; i < 3; i++) begin
      @(posedge clk); #1;
      n_total++;
      if ({upc, busy, done} !== {16'h0000, 1'b0, 1'b0})
        $display("FAIL post_reset %0d: got upc=%h busy=%b done=%b", i, upc, busy, done);
      else n_pass++;
    end
  endtask

`ifdef MICRO_SEQ_LOOP_CNT_EN
  task automatic test_loop();
    int k = 0;
    clear_rom();
    rom[0] = op_w(6'h3F) | 25'(16'h0003);
    rom[1] = op_w(6'd7);
    rom[2] = br_w(2'b11, 16'h0001);
    rom[3] = br_w(2'b00, 16'h0003);
    push(1,0,0,1, 16'h0000, 0, 6'd0, 1, 0);
    push(0,0,0,1, 16'h0001, 0, 6'd0, 1, 0);
    for (int i = 0; i < 3; i++) begin
      push(0,0,0,1, 16'h0002, 1, 6'd7, 1, 0);
      push(0,0,0,1, 16'h0001, 0, 6'd7, 1, 0);
    end
    push(0,0,0,1, 16'h0002, 1, 6'd7, 1, 0);
    push(0,0,0,1, 16'h0003, 0, 6'd7, 1, 0);
    push(0,0,0,1, 16'h0003, 0, 6'd7, 0, 1);
    push(0,0,0,1, 16'h0003, 0, 6'd7, 0, 0);
    while (sb.size() > 0) begin
      e = sb.pop_front();
      start = e.st; stall = e.sl; flag_zero = e.fz; flag_ext = e.fe;
      @(posedge clk); #1;
      n_total++; k++;
      if ({upc, ops_valid, ops_out, busy, done} !== {e.upc, e.v, e.ops, e.busy, e.done})
        $display("FAIL loop step %0d: got upc=%h v=%b ops=%h busy=%b done=%b want upc=%h v=%b ops=%h busy=%b done=%b",
                 k, upc, ops_valid, ops_out, busy, done, e.upc, e.v, e.ops, e.busy, e.done);
      else n_pass++;
    end
    start = 1'b0;
  endtask
`else
  task automatic test_ext();
    int k = 0;
    clear_rom();
    rom[0] = br_w(2'b11, 16'h0005);
    rom[5] = op_w(6'h3F);
    rom[6] = br_w(2'b00, 16'h0006);
    push(1,0,0,1, 16'h0000, 0, 6'd0, 1, 0);
    push(0,0,0,1, 16'h0005, 0, 6'd0, 1, 0);
    push(0,0,0,0, 16'h0006, 1, 6'h3F, 1, 0);
    push(0,0,0,0, 16'h0006, 0, 6'h3F, 0, 1);
    push(0,0,0,0, 16'h0006, 0, 6'h3F, 0, 0);
    while (sb.size() > 0) begin
      e = sb.pop_front();
      start = e.st; stall = e.sl; flag_zero = e.fz; flag_ext = e.fe;
      @(posedge clk); #1;
      n_total++; k++;
      if ({upc, ops_valid, ops_out, busy, done} !== {e.upc, e.v, e.ops, e.busy, e.done})
        $display("FAIL ext step %0d: got upc=%h v=%b ops=%h busy=%b done=%b want upc=%h v=%b ops=%h busy=%b done=%b",
                 k, upc, ops_valid, ops_out, busy, done, e.upc, e.v, e.ops, e.busy, e.done);
      else n_pass++;
    end
    start = 1'b0;
  endtask
`endif

  initial begin
    clear_rom();
    test_reset();
    test_ops_branch();
    test_stall();
    test_wrap_reset();
`ifdef MICRO_SEQ_LOOP_CNT_EN
    test_loop();
`else
    test_ext();
`endif
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL timeout: bench did not finish, passed=%0d total=%0d", n_pass, n_total);
    $fatal(1, "timeout");
  end
endmodule
